// File: rtl/pencoder4to2.sv
// rtl/pencoder4to2.sv - serialises a multi-hot 4-bit request vector into binary indices
// Accepts a vector in IDLE, then emits one index per handshake in priority order.
module pencoder4to2 #(
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [3:0] in,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [1:0] out,
    output logic       out_last
);

    typedef enum logic {
        IDLE = 1'b0,
        EMIT = 1'b1
    } state_t;

    state_t     state_q, state_d;
    logic [3:0] pending_q, pending_d;
    logic [1:0] out_q, out_d;
    logic       last_q, last_d;
    logic [3:0] clr_mask;
    logic [3:0] remain;

    function automatic logic [1:0] enc(input logic [3:0] v);
        logic [1:0] r;
        if (MSB_FIRST) begin
            r = v[3] ? 2'd3 : v[2] ? 2'd2 : v[1] ? 2'd1 : 2'd0;
        end else begin
            r = v[0] ? 2'd0 : v[1] ? 2'd1 : v[2] ? 2'd2 : 2'd3;
        end
        return r;
    endfunction

    function automatic logic one_hot(input logic [3:0] v);
        return (v != 4'd0) && ((v & (v - 4'd1)) == 4'd0);
    endfunction

    always_comb begin
        state_d   = state_q;
        pending_d = pending_q;
        out_d     = out_q;
        last_d    = last_q;
        clr_mask  = 4'b0001 << out_q;
        remain    = pending_q & ~clr_mask;
        case (state_q)
            IDLE: begin
                // Zero vectors are consumed silently; nothing to emit.
                if (in_valid && (in != 4'd0)) begin
                    state_d   = EMIT;
                    pending_d = in;
                    out_d     = enc(in);
                    last_d    = one_hot(in);
                end
            end
            EMIT: begin
                if (out_ready) begin
                    if (last_q) begin
                        state_d   = IDLE;
                        pending_d = 4'd0;
                        last_d    = 1'b0;
                    end else begin
                        pending_d = remain;
                        out_d     = enc(remain);
                        last_d    = one_hot(remain);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            pending_q <= 4'd0;
            out_q     <= 2'd0;
            last_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;
            out_q     <= out_d;
            last_q    <= last_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == EMIT);
    assign out       = out_q;
    assign out_last  = last_q;

endmodule

// File: doc/pencoder4to2.md
PENCODER4TO2 -- requirements
Module: pencoder4to2

Interface
REQ-001 The block SHALL have one parameter: MSB_FIRST, default 1, emission order of set bits (1 = bit 3 first, 0 = bit 0 first).
REQ-002 The block SHALL have port clk, input, 1 bit, single clock; all state updates on the rising edge.
REQ-003 The block SHALL have port rst_n, input, 1 bit, asynchronous active-low reset.
REQ-004 The block SHALL have port in_valid, input, 1 bit, request vector present on in.
REQ-005 The block SHALL have port in_ready, output, 1 bit, block can accept a request vector.
REQ-006 The block SHALL have port in, input, 4 bits, multi-hot request vector; bit i set means index i requested.
REQ-007 The block SHALL have port out_valid, output, 1 bit, encoded index present on out.
REQ-008 The block SHALL have port out_ready, input, 1 bit, downstream accepts the current index.
REQ-009 The block SHALL have port out, output, 2 bits, binary index of the current set bit.
REQ-010 The block SHALL have port out_last, output, 1 bit, current index is the final one of the accepted vector.

Function
REQ-011 The block SHALL implement two states, IDLE and EMIT, plus a 4-bit pending register.
REQ-012 In IDLE, in_ready SHALL be 1, out_valid 0, out_last 0, and out SHALL hold its last value (2'b00 after reset).
REQ-013 An input transfer SHALL occur on a rising edge with in_valid=1 and in_ready=1; in is sampled only at that edge and ignored otherwise.
REQ-014 An accepted in=4'b0000 SHALL be discarded: no output beat, state stays IDLE, in_ready stays 1.
REQ-015 An accepted nonzero in SHALL be loaded into pending and move the state to EMIT; out_valid SHALL be 1 in the cycle after the accepting edge (latency 1 cycle).
REQ-016 In EMIT, in_ready SHALL be 0; in_valid and in SHALL be ignored.
REQ-017 In EMIT, out SHALL be the index of the highest set pending bit (MSB_FIRST=1) or the lowest set pending bit (MSB_FIRST=0).
REQ-018 In EMIT, out_last SHALL be 1 exactly when pending has one bit set.
REQ-019 An output transfer SHALL occur on a rising edge with out_valid=1 and out_ready=1; it clears the emitted bit in pending.
REQ-020 An output transfer with out_last=1 SHALL return the state to IDLE, so in_ready=1 in the following cycle.
REQ-021 While out_valid=1 and out_ready=0, out, out_last and out_valid SHALL stay stable.
REQ-022 A vector with N set bits SHALL produce exactly N output beats in priority order, at most one per cycle, with no gaps while out_ready=1.
REQ-023 out, out_valid, out_last and in_ready SHALL be driven from registered state only, with no combinational path from in, in_valid or out_ready.
REQ-024 The minimum period between successive input transfers SHALL be N+1 cycles for a vector with N set bits (N>=1), and 1 cycle for zero vectors.

Reset
REQ-025 While rst_n=0, the state SHALL be IDLE, pending 4'b0000, out_valid 0, out_last 0, out 2'b00 and in_ready 1, and no transfer SHALL occur.
REQ-026 Assertion of rst_n in EMIT SHALL drop out_valid immediately (asynchronously) and discard all remaining pending bits.
REQ-027 After rst_n deasserts, the first input transfer SHALL be possible on the first rising edge.

Verification
REQ-028 The bench SHALL check: MSB_FIRST=1, in=4'b1010 accepted, out_ready=1 -> out=2'b11 with last=0, then out=2'b01 with last=1, then IDLE with in_ready=1.
REQ-029 The bench SHALL check: in=4'b0000 accepted -> out_valid stays 0 and in_ready stays 1 every cycle.
REQ-030 The bench SHALL check: in=4'b1111 with out_ready=0 for 3 cycles -> out=2'b11 held stable; then out_ready=1 -> beats 11,10,01,00 on consecutive cycles, last=1 only on 00.
REQ-031 The bench SHALL check: MSB_FIRST=0, in=4'b0110 -> out=2'b01 with last=0, then out=2'b10 with last=1.
REQ-032 The bench SHALL check: in=4'b1011, rst_n pulled low after the first beat (11) -> out_valid=0 immediately, in_ready=1, and no further beats after release.
REQ-033 The bench SHALL check: during EMIT for 4'b0100, in_valid=1 with in=4'b0001 -> not accepted until the cycle after the last beat, then emits out=2'b00.
